// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset vector, opcodes.
// Optional macro: FETCH_QUEUE_FLUSH_CNT_EN (flush statistics in fetch_queue).
package fetch_pkg;

  localparam int ST_RESET    = 0;
  localparam int ST_VEC_LO   = 1;
  localparam int ST_VEC_HI   = 2;
  localparam int ST_VEC_WAIT = 3;
  localparam int ST_STREAM   = 4;
  localparam int NSTATE      = 5;

  typedef enum logic [NSTATE-1:0] {
    S_RESET    = 5'b00001,
    S_VEC_LO   = 5'b00010,
    S_VEC_HI   = 5'b00100,
    S_VEC_WAIT = 5'b01000,
    S_STREAM   = 5'b10000
  } fetch_state_e;

  localparam logic [15:0] RESET_VEC_DEF = 16'hFFFC;

  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_JMP = 8'h4C;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } fq_entry_t;

  function automatic logic [15:0] sat_add16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x {pc,data} synchronous FIFO with push, pop, clear and count.
// Clear has priority over push/pop; pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  fq_entry_t              wdata_i,
  output fq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;
  logic            full;
  logic            do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage and pointer update; clear empties without touching entries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(push_i && full && !do_pop));
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: loads the reset vector, then streams bytes into a FIFO.
// Optional macro: FETCH_QUEUE_FLUSH_CNT_EN adds flush_cnt/flush_bytes outputs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [15:0] byte_pc,
  input  logic        byte_pop,
  output logic        vec_done
`ifdef FETCH_QUEUE_FLUSH_CNT_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] flush_bytes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [15:0]   fptr_q, fptr_d;
  logic [15:0]   addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          ret_q, ret_d;
  logic [15:0]   ret_pc_q;
  logic          vec_q, vec_d;

  logic          push, pop, clear, flush;
  logic [CW-1:0] count, count_nx;
  logic [CW:0]   need;
  logic          empty;
  fq_entry_t     head, wdata;

  assign pop   = byte_pop & ~empty;
  assign wdata = '{pc: ret_pc_q, data: mem_rd_data};

  // Next state, read issue and FIFO control.
  always_comb begin
    state_d  = state_q;
    fptr_d   = fptr_q;
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    ret_d    = 1'b0;
    vec_d    = vec_q;
    push     = 1'b0;
    clear    = 1'b0;
    flush    = 1'b0;
    count_nx = count;
    need     = '0;
    unique case (1'b1)
      state_q[ST_RESET]: begin
        state_d = S_VEC_LO;
        rd_en_d = 1'b1;
        addr_d  = RESET_VEC;
      end
      state_q[ST_VEC_LO]: begin
        state_d = S_VEC_HI;
        rd_en_d = 1'b1;
        addr_d  = RESET_VEC + 16'd1;
      end
      state_q[ST_VEC_HI]: begin
        state_d     = S_VEC_WAIT;
        fptr_d[7:0] = mem_rd_data;
      end
      state_q[ST_VEC_WAIT]: begin
        state_d      = S_STREAM;
        fptr_d[15:8] = mem_rd_data;
        vec_d        = 1'b1;
      end
      state_q[ST_STREAM]: begin
        flush    = redirect;
        clear    = redirect;
        push     = ret_q & ~redirect;
        ret_d    = rd_en_q & ~redirect;
        count_nx = redirect ? '0
                 : count + CW'(push) - CW'(pop);
        need     = {1'b0, count_nx} + (CW+1)'(ret_d);
        if (redirect) begin
          rd_en_d = 1'b1;
          addr_d  = redirect_addr;
          fptr_d  = redirect_addr + 16'd1;
        end else if (need < (CW+1)'(DEPTH)) begin
          rd_en_d = 1'b1;
          addr_d  = fptr_q;
          fptr_d  = fptr_q + 16'd1;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // State, fetch pointer and registered memory interface.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_RESET;
      fptr_q   <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      ret_q    <= 1'b0;
      ret_pc_q <= '0;
      vec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fptr_q   <= fptr_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      ret_q    <= ret_d;
      ret_pc_q <= addr_q;
      vec_q    <= vec_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign mem_addr   = addr_q;
  assign mem_rd_en  = rd_en_q;
  assign vec_done   = vec_q;
  assign byte_valid = ~empty;
  assign byte_data  = head.data;
  assign byte_pc    = head.pc;

`ifdef FETCH_QUEUE_FLUSH_CNT_EN
  logic [15:0] fcnt_q;
  logic [15:0] fbytes_q;

  // Saturating redirect and discarded-byte statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fcnt_q   <= '0;
      fbytes_q <= '0;
    end else if (flush) begin
      fcnt_q   <= sat_add16(fcnt_q, 16'd1);
      fbytes_q <= sat_add16(fbytes_q, 16'(count));
    end
  end

  assign flush_cnt   = fcnt_q;
  assign flush_bytes = fbytes_q;
`endif

endmodule
